// File: rtl/stack_pkg.sv
// Shared constants and helpers for the stack pointer bank.
package stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_NUM_STACKS = 2;

  // Well-known stack indices in the bank.
  localparam int STK_MAIN = 0;
  localparam int STK_RET = 1;

  // Bits needed to hold values 0 .. value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/stack_ptr_channel.sv
// One hardware stack pointer: pointer, occupancy, full/empty and sticky errors.
module stack_ptr_channel
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] BASE = '0,
  parameter logic GROW_DOWN = 1'b0,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             set_en,
  input  logic [WIDTH-1:0] set_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] push_addr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam logic [WIDTH-1:0] PTR_ONE = WIDTH'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] pop_addr;
  logic [WIDTH-1:0] sp_next;
  logic [CW-1:0]    count_next;
  logic             ovf_evt;
  logic             unf_evt;

  // Neighbouring slots: push_addr is where the next push lands, pop_addr is
  // where the pointer returns to after a pop. Both wrap modulo 2^WIDTH.
  assign push_addr = GROW_DOWN ? (sp - PTR_ONE) : (sp + PTR_ONE);
  assign pop_addr  = GROW_DOWN ? (sp + PTR_ONE) : (sp - PTR_ONE);

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  // Per-cycle priority: set, replace-top, refused pop, push, pop, hold.
  always_comb begin
    sp_next    = sp;
    count_next = count;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (set_en) begin
      sp_next    = set_val;
      count_next = '0;
    end else if (push && pop) begin
      // Replace-top leaves the pointer alone; with nothing to replace it is a
      // refused pop.
      if (empty) unf_evt = 1'b1;
    end else if (push) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        sp_next    = push_addr;
        count_next = count + CNT_ONE;
      end
    end else if (pop) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        sp_next    = pop_addr;
        count_next = count - CNT_ONE;
      end
    end
  end

  // State registers; a new error event in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp      <= BASE;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      sp      <= sp_next;
      count   <= count_next;
      ovf_err <= ovf_evt | (ovf_err & ~clr_err);
      unf_err <= unf_evt | (unf_err & ~clr_err);
    end
  end

endmodule

// File: rtl/stack_ptr_bank.sv
// Bank of NUM_STACKS independent stack pointers with packed port buses.
module stack_ptr_bank
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_STACKS = DEF_NUM_STACKS,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [NUM_STACKS*WIDTH-1:0] BASE = {16'hFFFF, 16'h0000},
  parameter logic [NUM_STACKS-1:0] GROW_DOWN = 2'b10,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_STACKS-1:0]       push,
  input  logic [NUM_STACKS-1:0]       pop,
  input  logic [NUM_STACKS-1:0]       set_en,
  input  logic [NUM_STACKS*WIDTH-1:0] set_val,
  input  logic                        clr_err,
  output logic [NUM_STACKS*WIDTH-1:0] sp,
  output logic [NUM_STACKS*WIDTH-1:0] push_addr,
  output logic [NUM_STACKS*CW-1:0]    count,
  output logic [NUM_STACKS-1:0]       full,
  output logic [NUM_STACKS-1:0]       empty,
  output logic [NUM_STACKS-1:0]       ovf_err,
  output logic [NUM_STACKS-1:0]       unf_err
);

  // One channel per stack; clr_err is shared by all of them.
  for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
    stack_ptr_channel #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .BASE     (BASE[i*WIDTH +: WIDTH]),
      .GROW_DOWN(GROW_DOWN[i])
    ) u_chan (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push[i]),
      .pop      (pop[i]),
      .set_en   (set_en[i]),
      .set_val  (set_val[i*WIDTH +: WIDTH]),
      .clr_err  (clr_err),
      .sp       (sp[i*WIDTH +: WIDTH]),
      .push_addr(push_addr[i*WIDTH +: WIDTH]),
      .count    (count[i*CW +: CW]),
      .full     (full[i]),
      .empty    (empty[i]),
      .ovf_err  (ovf_err[i]),
      .unf_err  (unf_err[i])
    );
  end

endmodule
